// File: rtl/axis_packetizer.sv
// axis_packetizer_pkg + axis_packetizer
//
// Purpose: this is the network-interface stage that sits in front of a router
// input channel. It takes one command (destination x/y and payload length)
// and a raw AXI-Stream payload. It emits one NoC packet: a routing header beat
// (TID = ROUTING_HEADER), then exactly LEN payload beats taken straight from
// the source. TLAST is set on the last payload beat, which is the beat where
// the downstream arbiter releases its grant.
//
// Ports:
//   clk_i, rst_n_i      clock; asynchronous active-low reset
//   cmd_valid_i/_ready_o command handshake
//   cmd_dest_x_i/_y_i   target router column / row
//   cmd_len_i           payload beats after the header (1..255; 0 is rejected)
//   s_mosi_i/s_miso_o   payload source (AXI-Stream slave side)
//   m_mosi_o/m_miso_i   towards the router input channel (AXI-Stream master)
//   busy_o              high while a packet is in flight
//   err_o               one-cycle pulse after a zero-length command
//   dbg_state_o         current FSM state (IDLE=0, HEADER=1, PAYLOAD=2)
//
// Handshake semantics (all three interfaces): a transfer happens on a rising
// clock edge where valid and ready are both high. The header beat holds valid
// and data stable until it is accepted. Payload beats mirror the source's
// valid, so the source stays responsible for its own stability.

package axis_packetizer_pkg;
  localparam int AXIS_DATA_WIDTH = 32;
  localparam int AXIS_ID_WIDTH   = 4;
  localparam int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;

  localparam logic [AXIS_ID_WIDTH-1:0] ROUTING_HEADER = '0;

  typedef struct packed {
    logic                       tvalid;
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic [AXIS_KEEP_WIDTH-1:0] tkeep;
    logic                       tlast;
    logic [AXIS_ID_WIDTH-1:0]   tid;
    logic                       tuser;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } pkt_state_e;
endpackage

module axis_packetizer
  import axis_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH    = AXIS_DATA_WIDTH,
  parameter int ID_WIDTH      = AXIS_ID_WIDTH,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int ROUTER_X      = 0,
  parameter int ROUTER_Y      = 0,
  parameter int PAYLOAD_TID   = 1,
  localparam int XW = $clog2(MAX_ROUTERS_X),
  localparam int YW = $clog2(MAX_ROUTERS_Y)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [XW-1:0] cmd_dest_x_i,
  input  logic [YW-1:0] cmd_dest_y_i,
  input  logic [7:0]    cmd_len_i,
  input  axis_mosi_t    s_mosi_i,
  output axis_miso_t    s_miso_o,
  output axis_mosi_t    m_mosi_o,
  input  axis_miso_t    m_miso_i,
  output logic          busy_o,
  output logic          err_o,
  output logic [1:0]    dbg_state_o
);

  // The bit positions of the header fields.
  localparam int DY_LO  = 0;
  localparam int DX_LO  = YW;
  localparam int SY_LO  = XW + YW;
  localparam int SX_LO  = XW + 2 * YW;
  localparam int LEN_LO = 2 * (XW + YW);

  // Elaboration-time sanity checks on the parameter set.
  if (DATA_WIDTH != AXIS_DATA_WIDTH) begin : g_chk_dw
    $error("axis_packetizer: DATA_WIDTH must match the axis_mosi_t TDATA width");
  end
  if (ID_WIDTH != AXIS_ID_WIDTH) begin : g_chk_idw
    $error("axis_packetizer: ID_WIDTH must match the axis_mosi_t TID width");
  end
  if (DATA_WIDTH < LEN_LO + 8) begin : g_chk_hdr
    $error("axis_packetizer: DATA_WIDTH too small for the routing header");
  end
  if (XW != YW) begin : g_chk_xy
    $error("axis_packetizer: X and Y coordinate widths must be equal");
  end
  if (PAYLOAD_TID == int'(ROUTING_HEADER)) begin : g_chk_tid
    $error("axis_packetizer: PAYLOAD_TID must differ from ROUTING_HEADER");
  end

  localparam logic [XW-1:0]       SRC_X   = XW'(ROUTER_X);
  localparam logic [YW-1:0]       SRC_Y   = YW'(ROUTER_Y);
  localparam logic [ID_WIDTH-1:0] PAY_TID = ID_WIDTH'(PAYLOAD_TID);

  pkt_state_e          state_q, state_d;
  logic [XW-1:0]       dest_x_q, dest_x_d;
  logic [YW-1:0]       dest_y_q, dest_y_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_WIDTH-1:0] header_w;

  // Routing header, built from the latched command. Unused upper bits are zero.
  always_comb begin
    header_w                        = '0;
    header_w[DY_LO +: YW]           = dest_y_q;
    header_w[DX_LO +: XW]           = dest_x_q;
    header_w[SY_LO +: YW]           = SRC_Y;
    header_w[SX_LO +: XW]           = SRC_X;
    header_w[LEN_LO +: 8]           = len_q;
  end

  always_comb begin
    state_d     = state_q;
    dest_x_d    = dest_x_q;
    dest_y_d    = dest_y_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    cmd_ready_o = 1'b0;
    m_mosi_o    = '0;
    s_miso_o    = '0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          if (cmd_len_i != 8'd0) begin
            dest_x_d = cmd_dest_x_i;
            dest_y_d = cmd_dest_y_i;
            len_d    = cmd_len_i;
            state_d  = ST_HEADER;
          end else begin
            // A zero-length command is consumed and produces no packet.
            err_d = 1'b1;
          end
        end
      end

      ST_HEADER: begin
        m_mosi_o.tvalid = 1'b1;
        m_mosi_o.tid    = ROUTING_HEADER;
        m_mosi_o.tdata  = header_w;
        if (m_miso_i.tready) begin
          cnt_d   = len_q;
          state_d = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        // Zero-latency pass-through. Only TID and TLAST are replaced. The
        // source's own TLAST is ignored because the count sets the boundary.
        m_mosi_o        = s_mosi_i;
        m_mosi_o.tid    = PAY_TID;
        m_mosi_o.tlast  = (cnt_q == 8'd1);
        s_miso_o.tready = m_miso_i.tready;
        if (s_mosi_i.tvalid && m_miso_i.tready) begin
          // cnt_q >= 1 here, because zero-length commands never leave IDLE.
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      dest_x_q <= '0;
      dest_y_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dest_x_q <= dest_x_d;
      dest_y_q <= dest_y_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule
